// File: rtl/sata_defines.sv
// SATA primitive dword constants and the 5-bit primitive ID encoding used
// between the receive primitive decoder and the link layer.
package sata_defines;

  localparam logic [31:0] PRIM_ALIGN   = 32'h7B4A_4ABC;
  localparam logic [31:0] PRIM_CONT    = 32'h9999_AA7C;
  localparam logic [31:0] PRIM_SYNC    = 32'hB5B5_957C;
  localparam logic [31:0] PRIM_X_RDY   = 32'h5757_B57C;
  localparam logic [31:0] PRIM_R_RDY   = 32'h4A4A_957C;
  localparam logic [31:0] PRIM_R_IP    = 32'h5555_B57C;
  localparam logic [31:0] PRIM_R_OK    = 32'h3535_B57C;
  localparam logic [31:0] PRIM_R_ERR   = 32'h5656_B57C;
  localparam logic [31:0] PRIM_SOF     = 32'h3737_B57C;
  localparam logic [31:0] PRIM_EOF     = 32'hD5D5_B57C;
  localparam logic [31:0] PRIM_WTRM    = 32'h5858_B57C;
  localparam logic [31:0] PRIM_HOLD    = 32'hD5D5_AA7C;
  localparam logic [31:0] PRIM_HOLDA   = 32'h9595_AA7C;
  localparam logic [31:0] PRIM_PMREQ_P = 32'h1717_B57C;
  localparam logic [31:0] PRIM_PMREQ_S = 32'h7575_957C;
  localparam logic [31:0] PRIM_PMACK   = 32'h9595_957C;
  localparam logic [31:0] PRIM_PMNACK  = 32'hF5F5_957C;
  localparam logic [31:0] PRIM_DMAT    = 32'h3636_B57C;

  typedef enum logic [4:0] {
    PRIM_ID_NONE    = 5'd0,
    PRIM_ID_SYNC    = 5'd1,
    PRIM_ID_X_RDY   = 5'd2,
    PRIM_ID_R_RDY   = 5'd3,
    PRIM_ID_R_IP    = 5'd4,
    PRIM_ID_R_OK    = 5'd5,
    PRIM_ID_R_ERR   = 5'd6,
    PRIM_ID_SOF     = 5'd7,
    PRIM_ID_EOF     = 5'd8,
    PRIM_ID_WTRM    = 5'd9,
    PRIM_ID_HOLD    = 5'd10,
    PRIM_ID_HOLDA   = 5'd11,
    PRIM_ID_PMREQ_P = 5'd12,
    PRIM_ID_PMREQ_S = 5'd13,
    PRIM_ID_PMACK   = 5'd14,
    PRIM_ID_PMNACK  = 5'd15,
    PRIM_ID_DMAT    = 5'd16,
    PRIM_ID_UNKNOWN = 5'd31
  } prim_id_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_NORMAL = 2'd1,
    ST_CONT   = 2'd2
  } dec_state_t;

endpackage

// File: rtl/sata_rx_prim_decoder_lookup.sv
// Combinational classifier: one receive dword + K flags to align/cont/data
// flags and a primitive ID (NONE for data, ALIGN and CONT).
module sata_prim_lookup
  import sata_defines::*;
(
  input  logic [31:0] rx_din,
  input  logic [3:0]  rx_is_k,
  output logic        is_align,
  output logic        is_cont,
  output logic        is_data,
  output prim_id_t    prim_id
);

  always_comb begin
    is_align = 1'b0;
    is_cont  = 1'b0;
    is_data  = 1'b0;
    prim_id  = PRIM_ID_NONE;
    if (rx_is_k == 4'b0000) begin
      is_data = 1'b1;
    end else if (rx_is_k == 4'b0001) begin
      case (rx_din)
        PRIM_ALIGN:   is_align = 1'b1;
        PRIM_CONT:    is_cont  = 1'b1;
        PRIM_SYNC:    prim_id  = PRIM_ID_SYNC;
        PRIM_X_RDY:   prim_id  = PRIM_ID_X_RDY;
        PRIM_R_RDY:   prim_id  = PRIM_ID_R_RDY;
        PRIM_R_IP:    prim_id  = PRIM_ID_R_IP;
        PRIM_R_OK:    prim_id  = PRIM_ID_R_OK;
        PRIM_R_ERR:   prim_id  = PRIM_ID_R_ERR;
        PRIM_SOF:     prim_id  = PRIM_ID_SOF;
        PRIM_EOF:     prim_id  = PRIM_ID_EOF;
        PRIM_WTRM:    prim_id  = PRIM_ID_WTRM;
        PRIM_HOLD:    prim_id  = PRIM_ID_HOLD;
        PRIM_HOLDA:   prim_id  = PRIM_ID_HOLDA;
        PRIM_PMREQ_P: prim_id  = PRIM_ID_PMREQ_P;
        PRIM_PMREQ_S: prim_id  = PRIM_ID_PMREQ_S;
        PRIM_PMACK:   prim_id  = PRIM_ID_PMACK;
        PRIM_PMNACK:  prim_id  = PRIM_ID_PMNACK;
        PRIM_DMAT:    prim_id  = PRIM_ID_DMAT;
        default:      prim_id  = PRIM_ID_UNKNOWN;
      endcase
    end else begin
      prim_id = PRIM_ID_UNKNOWN;
    end
  end

endmodule

// File: rtl/sata_rx_prim_decoder.sv
// SATA receive primitive decoder: drops ALIGN, expands CONT runs, registers a
// primitive/data stream with one cycle latency. Statistics counters are built
// only when SATA_RX_PRIM_STATS_EN is defined; otherwise they read zero.
module sata_rx_prim_decoder
  import sata_defines::*;
#(
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  phy_ready,
  input  logic [31:0]           rx_din,
  input  logic [3:0]            rx_is_k,
  output logic                  prim_valid,
  output prim_id_t              prim_id,
  output logic                  prim_from_cont,
  output logic                  data_valid,
  output logic [31:0]           data,
  output logic                  cont_error,
  output logic [STAT_WIDTH-1:0] align_drop_count,
  output logic [STAT_WIDTH-1:0] unknown_prim_count
);

  logic     lk_align, lk_cont, lk_data;
  prim_id_t lk_id;

  sata_prim_lookup u_lookup (
    .rx_din   (rx_din),
    .rx_is_k  (rx_is_k),
    .is_align (lk_align),
    .is_cont  (lk_cont),
    .is_data  (lk_data),
    .prim_id  (lk_id)
  );

  dec_state_t state, state_n;
  prim_id_t   held_prim, held_n;
  logic       pv_n, fc_n, dv_n, ce_n;
  prim_id_t   id_n;
  logic [31:0] data_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      held_prim      <= PRIM_ID_NONE;
      prim_valid     <= 1'b0;
      prim_id        <= PRIM_ID_NONE;
      prim_from_cont <= 1'b0;
      data_valid     <= 1'b0;
      data           <= '0;
      cont_error     <= 1'b0;
    end else begin
      state          <= state_n;
      held_prim      <= held_n;
      prim_valid     <= pv_n;
      prim_id        <= id_n;
      prim_from_cont <= fc_n;
      data_valid     <= dv_n;
      data           <= data_n;
      cont_error     <= ce_n;
    end
  end

  // IDLE keeps held_prim at NONE, so IDLE and NORMAL share one decode path.
  always_comb begin
    state_n = state;
    held_n  = held_prim;
    pv_n    = 1'b0;
    id_n    = PRIM_ID_NONE;
    fc_n    = 1'b0;
    dv_n    = 1'b0;
    data_n  = '0;
    ce_n    = 1'b0;
    if (!phy_ready) begin
      state_n = ST_IDLE;
      held_n  = PRIM_ID_NONE;
    end else if (lk_align) begin
      if (state == ST_IDLE) state_n = ST_NORMAL;
    end else if (state == ST_CONT && (lk_data || lk_cont)) begin
      pv_n = 1'b1;
      id_n = held_prim;
      fc_n = 1'b1;
    end else if (lk_data) begin
      state_n = ST_NORMAL;
      dv_n    = 1'b1;
      data_n  = rx_din;
    end else if (lk_cont) begin
      if (held_prim != PRIM_ID_NONE && held_prim != PRIM_ID_UNKNOWN) begin
        state_n = ST_CONT;
        pv_n    = 1'b1;
        id_n    = held_prim;
        fc_n    = 1'b1;
      end else begin
        state_n = ST_NORMAL;
        ce_n    = 1'b1;
      end
    end else begin
      state_n = ST_NORMAL;
      held_n  = lk_id;
      pv_n    = 1'b1;
      id_n    = lk_id;
    end
  end

`ifdef SATA_RX_PRIM_STATS_EN
  logic [STAT_WIDTH-1:0] align_cnt, unk_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      align_cnt <= '0;
      unk_cnt   <= '0;
    end else begin
      if (phy_ready && lk_align && align_cnt != '1)
        align_cnt <= align_cnt + STAT_WIDTH'(1);
      if (phy_ready && lk_id == PRIM_ID_UNKNOWN && unk_cnt != '1)
        unk_cnt <= unk_cnt + STAT_WIDTH'(1);
    end
  end

  assign align_drop_count   = align_cnt;
  assign unknown_prim_count = unk_cnt;
`else
  assign align_drop_count   = '0;
  assign unknown_prim_count = '0;
`endif

endmodule

// File: tb/tb_sata_rx_prim_decoder.sv
// Directed plus randomized bench for sata_rx_prim_decoder against a
// dword-level behavioural model (held primitive + CONT-run flag).
module tb_sata_rx_prim_decoder;
  import sata_defines::*;

  localparam int SW = 4;
  localparam int ID_ALIGN = -1;
  localparam int ID_CONT  = -2;
  localparam int ID_DATA  = -3;

  logic          clk = 1'b0;
  logic          rst;
  logic          phy_ready;
  logic [31:0]   rx_din;
  logic [3:0]    rx_is_k;
  logic          prim_valid;
  prim_id_t      prim_id;
  logic          prim_from_cont;
  logic          data_valid;
  logic [31:0]   data;
  logic          cont_error;
  logic [SW-1:0] align_drop_count;
  logic [SW-1:0] unknown_prim_count;

  sata_rx_prim_decoder #(.STAT_WIDTH(SW)) dut (
    .clk                (clk),
    .rst                (rst),
    .phy_ready          (phy_ready),
    .rx_din             (rx_din),
    .rx_is_k            (rx_is_k),
    .prim_valid         (prim_valid),
    .prim_id            (prim_id),
    .prim_from_cont     (prim_from_cont),
    .data_valid         (data_valid),
    .data               (data),
    .cont_error         (cont_error),
    .align_drop_count   (align_drop_count),
    .unknown_prim_count (unknown_prim_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int prim_map[logic [31:0]];
  logic [31:0] plist[16];
  logic [40:0] exp_q[$];
  int m_held;
  bit m_cont;
  int m_align, m_unk;

  function automatic int classify(logic [31:0] d, logic [3:0] k);
    if (k == 4'b0000) return ID_DATA;
    if (k != 4'b0001) return 31;
    if (prim_map.exists(d)) return prim_map[d];
    return 31;
  endfunction

  function automatic logic [40:0] pack(bit pv, int id, bit fc, bit dv, logic [31:0] d, bit ce);
    return {pv, 5'(id), fc, dv, d, ce};
  endfunction

  task automatic model(input logic [31:0] d, input logic [3:0] k, input bit rdy);
    int id;
    logic [40:0] e;
    id = classify(d, k);
    e  = '0;
    if (!rdy) begin
      m_cont = 0;
      m_held = 0;
    end else if (id == ID_ALIGN) begin
      if (m_align < (1 << SW) - 1) m_align++;
    end else if (m_cont && (id == ID_DATA || id == ID_CONT)) begin
      e = pack(1, m_held, 1, 0, 0, 0);
    end else if (id == ID_DATA) begin
      e = pack(0, 0, 0, 1, d, 0);
    end else if (id == ID_CONT) begin
      if (m_held != 0 && m_held != 31) begin
        m_cont = 1;
        e = pack(1, m_held, 1, 0, 0, 0);
      end else begin
        e = pack(0, 0, 0, 0, 0, 1);
      end
    end else begin
      m_cont = 0;
      m_held = id;
      if (id == 31 && m_unk < (1 << SW) - 1) m_unk++;
      e = pack(1, id, 0, 0, 0, 0);
    end
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag);
    logic [40:0] e, obs;
    logic [2*SW-1:0] ec, oc;
    e   = exp_q.pop_front();
    obs = {prim_valid, prim_id, prim_from_cont, data_valid, data, cont_error};
    n_cmp++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
`ifdef SATA_RX_PRIM_STATS_EN
    ec = {SW'(m_align), SW'(m_unk)};
`else
    ec = '0;
`endif
    oc = {align_drop_count, unknown_prim_count};
    n_cmp++;
    assert (oc === ec) else begin
      n_fail++;
      $error("FAIL %s_counters: observed %h expected %h", tag, oc, ec);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] d, input logic [3:0] k, input bit rdy);
    rx_din    = d;
    rx_is_k   = k;
    phy_ready = rdy;
    model(d, k, rdy);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    phy_ready = 1'b0;
    rx_din = '0;
    rx_is_k = '0;
    m_held = 0;
    m_cont = 0;
    m_align = 0;
    m_unk = 0;
    exp_q.push_back('0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check(tag);
  endtask

  initial begin
    plist = '{PRIM_ALIGN, PRIM_CONT, PRIM_SYNC, PRIM_X_RDY, PRIM_R_RDY, PRIM_R_IP,
              PRIM_R_OK, PRIM_R_ERR, PRIM_SOF, PRIM_EOF, PRIM_WTRM, PRIM_HOLD,
              PRIM_HOLDA, PRIM_PMREQ_P, PRIM_PMACK, PRIM_DMAT};
    prim_map[PRIM_ALIGN] = ID_ALIGN;  prim_map[PRIM_CONT] = ID_CONT;
    prim_map[PRIM_SYNC] = 1;    prim_map[PRIM_X_RDY] = 2;    prim_map[PRIM_R_RDY] = 3;
    prim_map[PRIM_R_IP] = 4;    prim_map[PRIM_R_OK] = 5;     prim_map[PRIM_R_ERR] = 6;
    prim_map[PRIM_SOF] = 7;     prim_map[PRIM_EOF] = 8;      prim_map[PRIM_WTRM] = 9;
    prim_map[PRIM_HOLD] = 10;   prim_map[PRIM_HOLDA] = 11;   prim_map[PRIM_PMREQ_P] = 12;
    prim_map[PRIM_PMREQ_S] = 13; prim_map[PRIM_PMACK] = 14;  prim_map[PRIM_PMNACK] = 15;
    prim_map[PRIM_DMAT] = 16;

    do_reset("reset");

    // ALIGNs dropped, then X_RDY
    step("t1_align0", PRIM_ALIGN, 4'b0001, 1);
    step("t1_align1", PRIM_ALIGN, 4'b0001, 1);
    step("t1_xrdy", PRIM_X_RDY, 4'b0001, 1);
    check_val("t1_xrdy_id", 32'(prim_id), 32'd2);

    // HOLD CONT run ended by HOLDA
    step("t2_hold0", PRIM_HOLD, 4'b0001, 1);
    step("t2_hold1", PRIM_HOLD, 4'b0001, 1);
    step("t2_cont", PRIM_CONT, 4'b0001, 1);
    check_val("t2_cont_flag", 32'(prim_from_cont), 32'd1);
    for (int i = 0; i < 3; i++) step("t2_junk", $urandom, 4'b0000, 1);
    check_val("t2_junk_id", 32'(prim_id), 32'd10);
    step("t2_holda", PRIM_HOLDA, 4'b0001, 1);
    check_val("t2_holda_flag", 32'(prim_from_cont), 32'd0);

    // CONT with nothing held
    do_reset("t3_reset");
    step("t3_cont", PRIM_CONT, 4'b0001, 1);
    check_val("t3_cont_error", 32'(cont_error), 32'd1);
    step("t3_data", 32'hDEAD_BEEF, 4'b0000, 1);
    check_val("t3_data_val", data, 32'hDEAD_BEEF);

    // ALIGN inside CONT run, then phy_ready drop abandons it
    step("t4_sync", PRIM_SYNC, 4'b0001, 1);
    step("t4_cont", PRIM_CONT, 4'b0001, 1);
    step("t4_junk", 32'h0BAD_F00D, 4'b0000, 1);
    step("t4_align", PRIM_ALIGN, 4'b0001, 1);
    step("t4_notready", 32'h5555_AAAA, 4'b0000, 0);
    step("t4_data", 32'h1234_5678, 4'b0000, 1);
    check_val("t4_data_val", data, 32'h1234_5678);

    // Unknown K patterns
    step("t5_badk", 32'hCAFE_0011, 4'b0011, 1);
    step("t5_unkprim", 32'h0000_00BC, 4'b0001, 1);
    check_val("t5_unk_id", 32'(prim_id), 32'd31);
    step("t5_cont_after_unk", PRIM_CONT, 4'b0001, 1);

    // Counter saturation and reset
    for (int i = 0; i < 20; i++) step("t6_align", PRIM_ALIGN, 4'b0001, 1);
    do_reset("t6_reset");

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      int r;
      bit rdy;
      rdy = ($urandom_range(0, 99) >= 8);
      r = $urandom_range(0, 99);
      if (r < 20)      step("rnd", $urandom, 4'b0000, rdy);
      else if (r < 35) step("rnd", PRIM_CONT, 4'b0001, rdy);
      else if (r < 45) step("rnd", PRIM_ALIGN, 4'b0001, rdy);
      else if (r < 50) step("rnd", $urandom, 4'($urandom_range(2, 15)), rdy);
      else if (r < 55) step("rnd", {$urandom_range(0, 65535), 16'h00BC}, 4'b0001, rdy);
      else             step("rnd", plist[$urandom_range(2, 15)], 4'b0001, rdy);
    end

    // Reset in the middle of a CONT run
    step("t7_sync", PRIM_SYNC, 4'b0001, 1);
    step("t7_cont", PRIM_CONT, 4'b0001, 1);
    step("t7_junk", 32'h7777_0000, 4'b0000, 1);
    do_reset("t7_reset");
    step("t7_data", 32'hA5A5_5A5A, 4'b0000, 1);
    step("t7_cont_err", PRIM_CONT, 4'b0001, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
